signed_mac_accumulator: RTL and testbench

- Downstream consumer of the combinational signed_multiplier.
- Instantiates signed_multiplier (N-bit operands, 2N-bit product) and accumulates LEN consecutive signed products into a saturating ACC_W-bit dot-product result.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.
- Sits between the operand source and the result consumer in the datapath.

---
 rtl/signed_mac_accumulator.sv | 200 ++++++++++++++++++++
 tb/tb_signed_mac_accumulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_mac_accumulator.sv
// Signed multiply-accumulate: sums LEN signed x*y products into a saturating
// ACC_W-bit result, with valid/ready handshakes on both the operand and result sides.

module signed_multiplier #(
  parameter int N = 5
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  logic signed [2*N-1:0] a_ext_s;
  logic signed [2*N-1:0] b_ext_s;

  // sign-extend both operands to full product width, then multiply
  always_comb begin
    a_ext_s = (2*N)'($signed(a));
    b_ext_s = (2*N)'($signed(b));
    p       = a_ext_s * b_ext_s;
  end

endmodule

module signed_mac_accumulator_chk #(
  parameter int ACC_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  input logic             clear,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [ACC_W-1:0] acc_out,
  input logic             overflow
);

  a_ready_valid_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));

  a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !clear) |=> (out_valid && $stable(acc_out) && $stable(overflow)));

endmodule

module signed_mac_accumulator #(
  parameter int N     = 5,
  parameter int ACC_W = 16,
  parameter int LEN   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] acc_out_r;
  logic             overflow_r;

  logic [2*N-1:0]   prod_s;
  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W:0]   sum_s;
  logic             clamp_s;
  logic [ACC_W-1:0] acc_next_s;
  logic             ovf_next_s;
  logic             xfer_s;
  logic             last_s;

  signed_multiplier #(.N(N)) u_mult (
    .a (x),
    .b (y),
    .p (prod_s)
  );

  // saturating next accumulator value; one guard bit exposes signed overflow
  always_comb begin
    prod_ext_s = ACC_W'($signed(prod_s));
    sum_s      = {prod_ext_s[ACC_W-1], prod_ext_s} + {acc_r[ACC_W-1], acc_r};
    if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
      clamp_s = 1'b1;
      if (sum_s[ACC_W]) begin
        acc_next_s = ACC_MIN;
      end else begin
        acc_next_s = ACC_MAX;
      end
    end else begin
      clamp_s    = 1'b0;
      acc_next_s = sum_s[ACC_W-1:0];
    end
    ovf_next_s = ovf_r | clamp_s;
    xfer_s     = (state_r == ST_ACCUM) && in_valid && in_ready_r;
    last_s     = (count_r == CNT_LAST);
  end

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_ACCUM;
      acc_r       <= {ACC_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      acc_out_r   <= {ACC_W{1'b0}};
      overflow_r  <= 1'b0;
    end else if (clear) begin
      state_r     <= ST_ACCUM;
      acc_r       <= {ACC_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      acc_out_r   <= {ACC_W{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (xfer_s) begin
            acc_r <= acc_next_s;
            ovf_r <= ovf_next_s;
            if (last_s) begin
              count_r     <= {CNT_W{1'b0}};
              acc_out_r   <= acc_next_s;
              overflow_r  <= ovf_next_s;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
              state_r     <= ST_DONE;
            end else begin
              count_r <= count_r + CNT_W'(1);
            end
          end else begin
            // also raises in_ready on the first edge after reset
            in_ready_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_valid_r && out_ready) begin
            acc_r       <= {ACC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_ACCUM;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_ACCUM;
          acc_r       <= {ACC_W{1'b0}};
          count_r     <= {CNT_W{1'b0}};
          ovf_r       <= 1'b0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          acc_out_r   <= {ACC_W{1'b0}};
          overflow_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign acc_out   = acc_out_r;
  assign overflow  = overflow_r;

  signed_mac_accumulator_chk #(.ACC_W(ACC_W)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_ready  (in_ready_r),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .acc_out   (acc_out_r),
    .overflow  (overflow_r)
  );

endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Bench for signed_mac_accumulator: a default-width and a 12-bit instance share
// stimulus and are compared each cycle against a queue-based saturating-sum model.

module tb_signed_mac_accumulator;

  localparam int N   = 5;
  localparam int LEN = 8;
  localparam int WA  = 16;
  localparam int WB  = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  x = '0;
  logic [N-1:0]  y = '0;
  logic          rdy_a, ov_a, of_a, rdy_b, ov_b, of_b;
  logic [WA-1:0] acc_a;
  logic [WB-1:0] acc_b;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int     prods[$];
  bit     m_rdy = 1'b0;
  bit     m_ov  = 1'b0;
  longint m_acc_a = 0, m_acc_b = 0;
  bit     m_of_a = 1'b0, m_of_b = 1'b0;

  signed_mac_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
    .x(x), .y(y), .out_valid(ov_a), .out_ready(out_ready), .acc_out(acc_a), .overflow(of_a)
  );

  signed_mac_accumulator #(.N(N), .ACC_W(WB), .LEN(LEN)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
    .x(x), .y(y), .out_valid(ov_b), .out_ready(out_ready), .acc_out(acc_b), .overflow(of_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat_sum(input int w, output bit of_o);
    longint lim = longint'(1) << (w - 1);
    longint s = 0;
    of_o = 1'b0;
    foreach (prods[i]) begin
      s = s + prods[i];
      if (s > lim - 1) begin
        s = lim - 1;
        of_o = 1'b1;
      end else if (s < -lim) begin
        s = -lim;
        of_o = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_rdy_a"}, rdy_a, m_rdy);
    chk({tag, "_rdy_b"}, rdy_b, m_rdy);
    chk({tag, "_ov_a"}, ov_a, m_ov);
    chk({tag, "_ov_b"}, ov_b, m_ov);
    chk({tag, "_acc_a"}, $signed(acc_a), m_acc_a);
    chk({tag, "_acc_b"}, $signed(acc_b), m_acc_b);
    chk({tag, "_of_a"}, of_a, m_of_a);
    chk({tag, "_of_b"}, of_b, m_of_b);
  endtask

  task automatic model_reset();
    prods.delete();
    m_rdy = 1'b0; m_ov = 1'b0;
    m_acc_a = 0; m_acc_b = 0; m_of_a = 1'b0; m_of_b = 1'b0;
  endtask

  // one clock with the given inputs, model update, then full comparison
  task automatic cycle(input string tag, input bit iv, input int xv, input int yv,
                       input bit ordy, input bit clr, output bit taken);
    int xs, ys;
    in_valid = iv; x = N'(xv); y = N'(yv); out_ready = ordy; clear = clr;
    xs = $signed(x); ys = $signed(y);
    taken = 1'b0;
    @(posedge clk);
    #1;
    if (clr) begin
      prods.delete();
      m_ov = 1'b0; m_rdy = 1'b1;
      m_acc_a = 0; m_acc_b = 0; m_of_a = 1'b0; m_of_b = 1'b0;
    end else if (m_ov) begin
      if (ordy) begin
        m_ov = 1'b0; m_rdy = 1'b1;
      end
    end else if (iv && m_rdy) begin
      taken = 1'b1;
      prods.push_back(xs * ys);
      if (prods.size() == LEN) begin
        m_acc_a = sat_sum(WA, m_of_a);
        m_acc_b = sat_sum(WB, m_of_b);
        prods.delete();
        m_ov = 1'b1; m_rdy = 1'b0;
      end
    end else begin
      m_rdy = 1'b1;
    end
    chk_all(tag);
  endtask

  task automatic feed(input string tag, input int n, input int xv, input int yv, input bit bubbles);
    int sent = 0;
    int guard = 0;
    bit t;
    while (sent < n && guard < 100) begin
      cycle(tag, bubbles ? (guard % 2 == 0) : 1'b1, xv, yv, 1'b0, 1'b0, t);
      if (t) sent++;
      guard++;
    end
    chk({tag, "_feed_bound"}, sent, n);
  endtask

  task automatic take(input string tag);
    bit t;
    cycle(tag, 1'b0, 0, 0, 1'b1, 1'b0, t);
  endtask

  initial begin
    bit t;
    // reset state, including one clock edge while held
    #12;
    model_reset();
    chk_all("reset");
    rst_n = 1'b1;
    cycle("first_edge", 1'b1, 3, -2, 1'b0, 1'b0, t);
    chk("first_edge_not_taken", t, 1'b0);

    feed("basic", 8, 3, -2, 1'b0);
    chk("basic_valid", ov_a, 1'b1);
    chk("basic_acc_a", $signed(acc_a), -48);
    chk("basic_acc_b", $signed(acc_b), -48);
    chk("basic_of_a", of_a, 1'b0);
    take("basic_take");

    feed("sat_pos", 8, -16, -16, 1'b0);
    chk("sat_pos_acc_b", $signed(acc_b), 2047);
    chk("sat_pos_of_b", of_b, 1'b1);
    chk("sat_pos_acc_a", $signed(acc_a), 2048);
    chk("sat_pos_of_a", of_a, 1'b0);
    take("sat_pos_take");

    feed("neg", 8, -16, 15, 1'b0);
    chk("neg_acc_b", $signed(acc_b), -1920);
    chk("neg_of_b", of_b, 1'b0);

    // backpressure with in_valid held high
    for (int i = 0; i < 5; i++) begin
      cycle("bp_hold", 1'b1, 7, 1, 1'b0, 1'b0, t);
      chk("bp_no_take", t, 1'b0);
    end
    chk("bp_acc_b_stable", $signed(acc_b), -1920);
    chk("bp_rdy", rdy_a, 1'b0);
    take("bp_take");
    chk("bp_ov_fell", ov_a, 1'b0);
    chk("bp_rdy_rose", rdy_a, 1'b1);

    feed("bubbles", 8, 1, 1, 1'b1);
    chk("bubbles_acc_a", $signed(acc_a), 8);
    take("bubbles_take");

    feed("clr_part", 3, 5, 5, 1'b0);
    cycle("clr_pulse", 1'b0, 0, 0, 1'b0, 1'b1, t);
    feed("after_clr", 8, 2, 2, 1'b0);
    chk("after_clr_acc_a", $signed(acc_a), 32);
    take("after_clr_take");

    feed("clr_iv_part", 2, 4, 4, 1'b0);
    cycle("clr_with_iv", 1'b1, 4, 4, 1'b0, 1'b1, t);
    chk("clr_with_iv_not_taken", t, 1'b0);
    feed("clr_iv_rest", 8, 1, 3, 1'b0);
    chk("clr_iv_acc_a", $signed(acc_a), 24);

    cycle("clr_done", 1'b0, 0, 0, 1'b0, 1'b1, t);
    chk("clr_done_ov", ov_a, 1'b0);
    chk("clr_done_acc", $signed(acc_a), 0);

    // asynchronous reset between edges, mid-accumulation
    feed("pre_rst", 4, 7, 7, 1'b0);
    #3 rst_n = 1'b0;
    #1 model_reset();
    chk_all("async_rst");
    #2 rst_n = 1'b1;
    feed("post_rst", 8, -1, 5, 1'b0);
    chk("post_rst_acc_a", $signed(acc_a), -40);
    take("post_rst_take");

    // randomized traffic, half of it biased toward operand extremes
    for (int i = 0; i < 600; i++) begin
      int xv, yv;
      if (i >= 300) begin
        xv = ($urandom_range(0, 1) == 0) ? -16 : 15;
        yv = ($urandom_range(0, 1) == 0) ? -16 : 15;
      end else begin
        xv = int'($urandom_range(0, 31));
        yv = int'($urandom_range(0, 31));
      end
      cycle("rand", $urandom_range(0, 9) < 7, xv, yv, $urandom_range(0, 2) == 0,
            $urandom_range(0, 59) == 0, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
